// File: rtl/noc_ring_mesh_router.sv
// Five-port source-routed ring/mesh NoC router using even/odd VC double-buffering.
// Optional macro RR_ARB_EN selects round-robin output arbitration instead of fixed priority.
module noc_ring_mesh_router #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        router_position,
  output logic              polarity_out,
  input  logic              cwsi,
  input  logic              ccwsi,
  input  logic              nssi,
  input  logic              snsi,
  input  logic              pesi,
  input  logic [DATA_W-1:0] cwdi,
  input  logic [DATA_W-1:0] ccwdi,
  input  logic [DATA_W-1:0] nsdi,
  input  logic [DATA_W-1:0] sndi,
  input  logic [DATA_W-1:0] pedi,
  output logic              cwri,
  output logic              ccwri,
  output logic              nsri,
  output logic              snri,
  output logic              peri,
  output logic              cwso,
  output logic              ccwso,
  output logic              nsso,
  output logic              snso,
  output logic              peso,
  output logic [DATA_W-1:0] cwdo,
  output logic [DATA_W-1:0] ccwdo,
  output logic [DATA_W-1:0] nsdo,
  output logic [DATA_W-1:0] sndo,
  output logic [DATA_W-1:0] pedo,
  input  logic              cwro,
  input  logic              ccwro,
  input  logic              nsro,
  input  logic              snro,
  input  logic              pero
);

  localparam int unsigned NP = 5;

  typedef enum logic [2:0] {PortCw, PortCcw, PortNs, PortSn, PortPe} port_e;

  logic              p_q;
  logic              v;
  logic [NP-1:0]     si, ro;
  logic [DATA_W-1:0] di [NP];

  logic [1:0]        in_vld_q   [NP];
  logic [DATA_W-1:0] in_data_q  [NP][2];
  logic [1:0]        out_vld_q  [NP];
  logic [DATA_W-1:0] out_data_q [NP][2];
  logic [NP-1:0]     so_q;
  logic [DATA_W-1:0] do_q [NP];

  port_e             req_port [NP];
  logic [DATA_W-1:0] req_data [NP];
  logic [NP-1:0]     in_clr, out_set;
  logic [DATA_W-1:0] out_new [NP];
  logic [2:0]        idx;
`ifdef RR_ARB_EN
  logic [2:0]        rr_ptr_q [NP][2];
  logic [2:0]        gnt [NP];
  logic [3:0]        rr_sum;
`endif

  logic unused_pos;
  assign unused_pos = ^router_position;

  // Crossbar works on the VC opposite to the one the links are using this cycle.
  assign v            = ~p_q;
  assign polarity_out = p_q;

  assign si = {pesi, snsi, nssi, ccwsi, cwsi};
  assign ro = {pero, snro, nsro, ccwro, cwro};
  assign di[0] = cwdi;
  assign di[1] = ccwdi;
  assign di[2] = nsdi;
  assign di[3] = sndi;
  assign di[4] = pedi;

  assign cwri  = ~in_vld_q[0][v];
  assign ccwri = ~in_vld_q[1][v];
  assign nsri  = ~in_vld_q[2][v];
  assign snri  = ~in_vld_q[3][v];
  assign peri  = ~in_vld_q[4][v];

  assign {peso, snso, nsso, ccwso, cwso} = so_q;
  assign cwdo  = do_q[0];
  assign ccwdo = do_q[1];
  assign nsdo  = do_q[2];
  assign sndo  = do_q[3];
  assign pedo  = do_q[4];

  // Dimension-ordered route: x hops first, then y, else deliver locally.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      req_data[i] = in_data_q[i][v];
      req_port[i] = PortPe;
      if (in_data_q[i][v][51:48] != 4'd0) begin
        req_port[i]        = in_data_q[i][v][61] ? PortCcw : PortCw;
        req_data[i][51:48] = in_data_q[i][v][51:48] - 4'd1;
      end else if (in_data_q[i][v][55:52] != 4'd0) begin
        req_port[i]        = in_data_q[i][v][62] ? PortSn : PortNs;
        req_data[i][55:52] = in_data_q[i][v][55:52] - 4'd1;
      end
    end
  end

  always_comb begin
    in_clr  = '0;
    out_set = '0;
    idx     = '0;
`ifdef RR_ARB_EN
    rr_sum  = '0;
`endif
    for (int o = 0; o < NP; o++) begin
      out_new[o] = '0;
`ifdef RR_ARB_EN
      gnt[o]     = '0;
`endif
      if (!out_vld_q[o][v]) begin
        for (int k = 0; k < NP; k++) begin
`ifdef RR_ARB_EN
          rr_sum = {1'b0, rr_ptr_q[o][v]} + 4'(k);
          idx    = 3'((rr_sum >= 4'd5) ? rr_sum - 4'd5 : rr_sum);
`else
          idx    = 3'(k);
`endif
          if (!out_set[o] && in_vld_q[idx][v] && req_port[idx] == port_e'(o)) begin
            out_set[o]  = 1'b1;
            out_new[o]  = req_data[idx];
            in_clr[idx] = 1'b1;
`ifdef RR_ARB_EN
            gnt[o]      = idx;
`endif
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_q  <= 1'b0;
      so_q <= '0;
      for (int i = 0; i < NP; i++) begin
        in_vld_q[i]  <= '0;
        out_vld_q[i] <= '0;
        do_q[i]      <= '0;
        for (int b = 0; b < 2; b++) begin
          in_data_q[i][b]  <= '0;
          out_data_q[i][b] <= '0;
`ifdef RR_ARB_EN
          rr_ptr_q[i][b]   <= '0;
`endif
        end
      end
    end else begin
      p_q <= ~p_q;
      for (int i = 0; i < NP; i++) begin
        // A strobe into an already-full buffer is a sender error; the data is dropped.
        if (si[i] && !in_vld_q[i][p_q]) begin
          in_vld_q[i][p_q]  <= 1'b1;
          in_data_q[i][p_q] <= di[i];
        end
        if (in_clr[i]) in_vld_q[i][v] <= 1'b0;
        if (out_set[i]) begin
          out_vld_q[i][v]  <= 1'b1;
          out_data_q[i][v] <= out_new[i];
`ifdef RR_ARB_EN
          rr_ptr_q[i][v]   <= (gnt[i] == 3'd4) ? 3'd0 : gnt[i] + 3'd1;
`endif
        end
        if (out_vld_q[i][p_q] && ro[i]) begin
          so_q[i]           <= 1'b1;
          do_q[i]           <= out_data_q[i][p_q];
          out_vld_q[i][p_q] <= 1'b0;
        end else begin
          so_q[i] <= 1'b0;
          do_q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_noc_ring_mesh_router.sv
// Directed bench for noc_ring_mesh_router: reset, routing, latency, contention and backpressure.
module tb_noc_ring_mesh_router;

  localparam int CW = 0, CCW = 1, NS = 2, SN = 3, PE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  pos = 4'd5;
  logic [4:0]  si = '0;
  logic [4:0]  ro = 5'b11111;
  logic [63:0] di [5];
  logic [4:0]  so, ri;
  logic [63:0] dout [5];
  logic        pol;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  noc_ring_mesh_router dut (
    .clk(clk), .reset(reset), .router_position(pos), .polarity_out(pol),
    .cwsi(si[0]), .ccwsi(si[1]), .nssi(si[2]), .snsi(si[3]), .pesi(si[4]),
    .cwdi(di[0]), .ccwdi(di[1]), .nsdi(di[2]), .sndi(di[3]), .pedi(di[4]),
    .cwri(ri[0]), .ccwri(ri[1]), .nsri(ri[2]), .snri(ri[3]), .peri(ri[4]),
    .cwso(so[0]), .ccwso(so[1]), .nsso(so[2]), .snso(so[3]), .peso(so[4]),
    .cwdo(dout[0]), .ccwdo(dout[1]), .nsdo(dout[2]), .sndo(dout[3]), .pedo(dout[4]),
    .cwro(ro[0]), .ccwro(ro[1]), .nsro(ro[2]), .snro(ro[3]), .pero(ro[4])
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge; strobe in cycle N, expect a one-cycle pulse in cycle N+3.
  task automatic send(input int src, input logic [63:0] d, input int dst,
                      input logic [63:0] exp, input string tag);
    check({tag, "_ri"}, 64'(ri[src]), 64'd1);
    @(posedge clk); #1;
    si[src] = 1'b1;
    di[src] = d;
    @(posedge clk); #1;
    si[src] = 1'b0;
    di[src] = '0;
    @(negedge clk);
    check({tag, "_n1"}, 64'(so[dst]), 64'd0);
    @(negedge clk);
    check({tag, "_n2"}, 64'(so[dst]), 64'd0);
    @(negedge clk);
    check({tag, "_so"}, 64'(so[dst]), 64'd1);
    check({tag, "_do"}, dout[dst], exp);
    @(negedge clk);
    check({tag, "_n4"}, 64'(so[dst]), 64'd0);
  endtask

  task automatic wait_so(input int port, input logic [63:0] exp, input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (so[port] === 1'b1) seen = 1'b1;
    end
    check({tag, "_seen"}, 64'(seen), 64'd1);
    if (seen) check({tag, "_data"}, dout[port], exp);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) di[i] = '0;

    // Reset held for two cycles
    repeat (2) @(negedge clk);
    check("rst_so", 64'(so), 64'd0);
    for (int i = 0; i < 5; i++) check($sformatf("rst_do%0d", i), dout[i], 64'd0);
    reset = 1'b1;
    #1;
    check("rst_ri", 64'(ri), 64'h1f);
    check("pol0", 64'(pol), 64'd0);
    @(negedge clk);
    check("pol1", 64'(pol), 64'd1);
    @(negedge clk);
    check("pol2", 64'(pol), 64'd0);

    send(PE, 64'h2002_0000_0000_FA50, CCW, 64'h2001_0000_0000_FA50, "pe_ccw");
    send(NS, 64'h0002_0000_000F_BA34, CW, 64'h0001_0000_000F_BA34, "ns_cw");
    send(CCW, 64'h4020_0000_0000_C7D4, SN, 64'h4010_0000_0000_C7D4, "ccw_sn");
    send(SN, 64'h0000_0000_0000_1234, PE, 64'h0000_0000_0000_1234, "sn_pe");
    send(CW, 64'h0010_0000_0000_0055, NS, 64'h0000_0000_0000_0055, "cw_ns");
    send(PE, 64'h8011_0000_0000_0077, CW, 64'h8010_0000_0000_0077, "rsv_cw");

    // Contention on ccw with the downstream stalled
    ro[CCW] = 1'b0;
    @(posedge clk); #1;
    si[CW] = 1'b1; di[CW] = 64'h2002_0000_0000_00A1;
    si[PE] = 1'b1; di[PE] = 64'h2002_0000_0000_00B2;
    @(posedge clk); #1;
    si = '0;
    di[CW] = '0;
    di[PE] = '0;
    @(negedge clk);
    check("ct_ri_pe_n1", 64'(ri[PE]), 64'd0);
    check("ct_ri_cw_n1", 64'(ri[CW]), 64'd0);
    @(negedge clk);
    check("ct_ri_pe_n2", 64'(ri[PE]), 64'd1);
    @(negedge clk);
    check("ct_ri_pe_n3", 64'(ri[PE]), 64'd0);
    check("ct_ri_cw_n3", 64'(ri[CW]), 64'd1);
    check("ct_so_n3", 64'(so[CCW]), 64'd0);
    repeat (4) @(negedge clk);
    check("ct_stall_so", 64'(so[CCW]), 64'd0);
    check("ct_stall_ri", 64'(ri[PE]), 64'd0);
    ro[CCW] = 1'b1;
    wait_so(CCW, 64'h2001_0000_0000_00A1, "ct_first");
    wait_so(CCW, 64'h2001_0000_0000_00B2, "ct_second");
    repeat (3) @(negedge clk);
    check("ct_drain_ri", 64'(ri), 64'h1f);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/noc_ring_mesh_router.md
Name: noc_ring_mesh_router

Overview:
- Five-port, 64-bit, source-routed router for one node of a ring/mesh network-on-chip.
- Ring links are cw and ccw; mesh links are ns and sn; one local processing-element (pe) port.
- Uses even/odd virtual-channel (VC) double-buffering driven by a global polarity bit. External links and the internal crossbar work on opposite VCs, so a link transfer and a switch transfer never touch the same buffer in one cycle.

Parameters:
- DATA_W, 64, packet width. Must be at least 64 because header bits [63:48] are fixed.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- router_position  in  4  node ID; debug only, not used for routing
- polarity_out  out  1  current polarity p
- cwsi/ccwsi/nssi/snsi/pesi  in  1  input-link send strobe
- cwdi/ccwdi/nsdi/sndi/pedi  in  64  input-link data
- cwri/ccwri/nsri/snri/peri  out  1  input-link ready
- cwso/ccwso/nsso/snso/peso  out  1  output-link send strobe
- cwdo/ccwdo/nsdo/sndo/pedo  out  64  output-link data
- cwro/ccwro/nsro/snro/pero  in  1  output-link ready from downstream

Behaviour:
- Header fields:
  - [63] reserved, passed through unchanged.
  - [62] y direction: 0 = ns, 1 = sn.
  - [61] x direction: 0 = cw, 1 = ccw.
  - [55:52] y hop count.
  - [51:48] x hop count.
  - [60:56] and [47:0] are payload, passed unchanged.
- Route selection, x before y:
  - x hops != 0: output is cw or ccw per [61]; x hops decremented by 1.
  - else y hops != 0: output is ns or sn per [62]; y hops decremented by 1.
  - else: output is pe, packet unchanged.
  - The rule is the same for every input port; U-turns are allowed.
- Storage:
  - Per input port: in_buf[0], in_buf[1], each one 64-bit entry plus a valid flag.
  - Per output port: out_buf[0], out_buf[1], same structure.
- Polarity:
  - Register p, reset to 0, toggles every cycle after reset.
  - polarity_out = p.
- Input ready: xri = ~valid(in_buf[~p]), combinational from registered state.
- Input capture at posedge: if xsi=1, in_buf[p] <= xdi and is marked valid.
  - Sender contract: xsi may be high only in the cycle after xri was sampled high.
  - xsi with the target buffer already valid is a protocol violation; the data is dropped and the buffer is not overwritten.
- Crossbar at posedge, working on VC v = ~p:
  - Each valid in_buf[v] requests its routed output.
  - The move happens only if the target out_buf[v] is empty at cycle start.
  - The winner moves with its hop field updated; its in_buf[v] is cleared.
  - Losers hold.
  - Fixed priority: cw > ccw > ns > sn > pe.
- Launch at posedge:
  - Condition: out_buf[p] valid and xro=1.
  - Then xso <= 1, xdo <= entry, and out_buf[p] is cleared.
  - Otherwise xso <= 0 and xdo <= 0.
  - xso/xdo are registered and high for exactly one cycle per packet.
- Latency: xsi high in cycle N gives yso high in cycle N+3, when uncontended and ro is high.
- Backpressure: if xro=0, the entry holds indefinitely; the VC input can refill the other buffer.
- Simultaneous events: in one edge, capture, crossbar and launch touch disjoint buffers, so all may occur together.
- Reset, asynchronous and active-low, also mid-traffic:
  - All valid flags cleared.
  - p=0.
  - All so=0, all do=0.
  - All ri=1 once reset is released.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: each output uses a round-robin arbiter, with a separate pointer per VC. Priority starts just after the last grant; the pointer resets to cw.
- Undefined: fixed priority cw > ccw > ns > sn > pe.

Test Plan:
- Reset held (reset=0) 2 cycles, then released:
  - all so=0 and do=0; all ri=1; polarity_out toggles 0,1,0,... each cycle.
- Inject 0x2002_0000_0000_FA50 on pe with ccwro=1:
  - ccwso pulses in cycle N+3 with ccwdo=0x2002_0000_0000_FA50 minus the hop decrement, i.e. 0x2001_0000_0000_FA50.
- Inject 0x0002_0000_000F_BA34 with cwro=1:
  - exits cw as 0x0001_0000_000F_BA34.
- Inject 0x4020_0000_0000_C7D4 with snro=1:
  - x hops are zero, so it exits sn as 0x4010_0000_0000_C7D4.
- Inject 0x0000_0000_0000_1234:
  - hop fields are zero, so pedo=0x0000_0000_0000_1234 with peso pulsed.
- Contention and backpressure: with ccwro=0, cw and pe each inject an 0x2002… packet in the same cycle:
  - the cw packet occupies out_buf and stalls; the pe packet stalls in in_buf and its peri drops.
  - Raise ccwro: the cw packet leaves first, then the pe packet.
  - With RR_ARB_EN defined, the order alternates on a repeat of the test.
